fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 15'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter IRQ_VEC, default 15'h0010, SHALL be the PC value loaded on interrupt entry.
REQ-003 Port CLK, input, 1: SHALL be the single clock; all state updates on posedge CLK.
REQ-004 Port CLR, input, 1: SHALL be a synchronous, active-high reset.
REQ-005 Port run, input, 1: SHALL enable fetching when 1.
REQ-006 Port stall, input, 1: SHALL suppress new fetch requests when 1.
REQ-007 Port branch_valid, input, 1: SHALL request a redirect to branch_addr.
REQ-008 Port branch_addr, input, 15: SHALL be the redirect target.
REQ-009 Port irq, input, 1: SHALL be a level-sensitive interrupt request.
REQ-010 Port irq_ret, input, 1: SHALL be a return-from-interrupt request.
REQ-011 Port imem_req, output, 1: SHALL be the memory request.
REQ-012 Port imem_addr, output, 15: SHALL be the memory address.
REQ-013 Port imem_ack, input, 1: SHALL be the memory acknowledge.
REQ-014 Port imem_data, input, 16: SHALL be the read data, valid when imem_ack=1.
REQ-015 Port instr_valid, output, 1: SHALL be a one-cycle delivery strobe.
REQ-016 Port instr, output, 16: SHALL be the delivered word.
REQ-017 Port instr_pc, output, 15: SHALL be the delivered word's address.
REQ-018 Port irq_ack, output, 1: SHALL be a one-cycle interrupt-taken pulse.
REQ-019 Port in_isr, output, 1: SHALL be the interrupt-active flag.

Function
REQ-020 The FSM SHALL have three states: IDLE (imem_req=0), FETCH (imem_req=1), and HOLD (imem_req=0).
REQ-021 Transitions SHALL be: IDLE->FETCH when run=1 and stall=0; FETCH stays FETCH after each transfer; FETCH->HOLD when a transfer completes with stall=1; FETCH->IDLE when a transfer completes with run=0; HOLD->FETCH when stall=0 and run=1; HOLD->IDLE when run=0.
REQ-022 A transfer SHALL complete on any edge where imem_req=1 and imem_ack=1; while imem_req=1 and no transfer has completed, imem_addr SHALL remain stable.
REQ-023 For a zero-wait memory, the block SHALL sustain one transfer per cycle.
REQ-024 On a non-discarded transfer, the next cycle SHALL show instr=imem_data, instr_pc=the fetched address, and instr_valid=1; otherwise instr_valid SHALL be 0 and instr/instr_pc SHALL hold their values.
REQ-025 Next-PC priority at each transfer or idle redirect SHALL be: branch > irq > irq_ret > pc+1.
REQ-026 The PC SHALL increment modulo 2^15, so 15'h7FFF+1 = 15'h0000 with no flag.
REQ-027 Branch while a request is outstanding without ack: the target SHALL be latched in a redirect-pending register, and the ack SHALL discard the word and load the target.
REQ-028 Branch in the same cycle as an ack: the word SHALL be discarded and the target loaded.
REQ-029 Branch in IDLE or HOLD: the PC SHALL load the target on the next edge; a later branch SHALL overwrite a pending one.
REQ-030 irq SHALL be taken only at a non-discarded transfer with in_isr=0 and no branch that cycle: epc<=pc+1, pc<=IRQ_VEC, in_isr<=1, irq_ack pulses, and the completing word is still delivered.
REQ-031 irq while in_isr=1, or while a branch is taken, SHALL stay pending (level) and be taken at the next eligible transfer.
REQ-032 irq_ret with in_isr=1 at a transfer SHALL set pc<=epc and in_isr<=0; irq_ret with in_isr=0 SHALL be ignored.

Reset
REQ-033 CLR=1 at any edge SHALL set state=IDLE, pc=RESET_VEC, epc=0, redirect-pending=0, in_isr=0, and all outputs to 0.
REQ-034 A request outstanding at reset SHALL be abandoned; the memory SHALL tolerate imem_req deasserting.
REQ-035 CLR SHALL take priority over every other input.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the 15-bit address width, and the 16-bit instruction width.
REQ-037 The block SHALL contain one sub-module, fetch_pc_reg: a 15-bit register with synchronous clear-to-value, load, hold, and increment.

Verification
REQ-038 CLR, then run=1 with zero-wait memory: imem_addr=0,1,2,3 on consecutive cycles, with instr_valid continuous.
REQ-039 Memory with 2 wait states, branch_addr=15'h0100 asserted during the wait: imem_addr is stable until ack, the word is discarded, and the next imem_addr=15'h0100.
REQ-040 pc=15'h7FFF fetch: the next imem_addr=15'h0000.
REQ-041 irq at a transfer of pc=15'h0020: irq_ack=1, next imem_addr=IRQ_VEC, in_isr=1; later irq_ret gives next imem_addr=15'h0021 and in_isr=0.
REQ-042 stall=1 during a transfer: state=HOLD with imem_req=0; branch to 15'h0040 during HOLD, then stall=0 gives first imem_addr=15'h0040.
REQ-043 CLR asserted mid-wait: the next cycle shows imem_req=0, pc=RESET_VEC, and in_isr=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   ADDR_W        : program counter / memory address width
//   INSTR_W       : instruction word width
//   fetch_state_e : fetch FSM state encoding
package fetch_sequencer_pkg;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register.
// Ports:
//   CLK      : clock
//   clr      : synchronous clear, loads clr_val (highest priority)
//   clr_val  : value loaded by clr
//   load     : load load_val
//   load_val : value loaded by load
//   inc      : increment by one, wrapping at 2^ADDR_W
//   pc       : current register value
module fetch_pc_reg
    import fetch_sequencer_pkg::*;
(
    input  logic              CLK,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_val,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = clr_val;
        end else if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            // Natural wrap: 7FFF + 1 = 0000, no carry kept.
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues memory requests from the PC, delivers
// returned words, and handles branches, interrupt entry and interrupt return.
// Ports:
//   CLK, CLR                : clock, synchronous active-high reset
//   run, stall              : fetch enable, suppress new requests
//   branch_valid/_addr      : redirect request and target
//   irq, irq_ret            : level interrupt request, return from interrupt
//   imem_req/_addr          : memory request and address
//   imem_ack/_data          : memory acknowledge and read data
//   instr_valid/instr/_pc   : one-cycle delivery strobe, word, word address
//   irq_ack, in_isr         : interrupt-taken pulse, interrupt-active flag
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VEC = 15'h0000,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = 15'h0010
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               run,
    input  logic               stall,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               irq,
    input  logic               irq_ret,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               irq_ack,
    output logic               in_isr
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc, pc_plus1, pc_load_val;
    logic               pc_load, pc_inc;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic               redir_pend_q, redir_pend_d;
    logic [ADDR_W-1:0]  redir_addr_q, redir_addr_d;
    logic               in_isr_q, in_isr_d;
    logic               irq_ack_q, irq_ack_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               xfer;

    fetch_pc_reg u_pc_reg (
        .CLK      (CLK),
        .clr      (CLR),
        .clr_val  (RESET_VEC),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign pc_plus1 = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign xfer     = (state_q == StFetch) && imem_ack;

    always_comb begin
        state_d       = state_q;
        pc_load       = 1'b0;
        pc_load_val   = pc;
        pc_inc        = 1'b0;
        epc_d         = epc_q;
        redir_pend_d  = redir_pend_q;
        redir_addr_d  = redir_addr_q;
        in_isr_d      = in_isr_q;
        irq_ack_d     = 1'b0;
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            StIdle: begin
                if (branch_valid) begin
                    pc_load     = 1'b1;
                    pc_load_val = branch_addr;
                end
                if (run && !stall) begin
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (branch_valid) begin
                    pc_load     = 1'b1;
                    pc_load_val = branch_addr;
                end
                if (!run) begin
                    state_d = StIdle;
                end else if (!stall) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (xfer) begin
                    if (branch_valid || redir_pend_q) begin
                        // Word fetched from the old stream is dropped.
                        pc_load      = 1'b1;
                        pc_load_val  = branch_valid ? branch_addr : redir_addr_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem_data;
                        instr_pc_d    = pc;
                        if (irq && !in_isr_q) begin
                            epc_d       = pc_plus1;
                            pc_load     = 1'b1;
                            pc_load_val = IRQ_VEC;
                            in_isr_d    = 1'b1;
                            irq_ack_d   = 1'b1;
                        end else if (irq_ret && in_isr_q) begin
                            pc_load     = 1'b1;
                            pc_load_val = epc_q;
                            in_isr_d    = 1'b0;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                    if (!run) begin
                        state_d = StIdle;
                    end else if (stall) begin
                        state_d = StHold;
                    end
                end else if (branch_valid) begin
                    // Address must stay stable until ack; remember the target.
                    redir_pend_d = 1'b1;
                    redir_addr_d = branch_addr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q       <= StIdle;
            epc_q         <= '0;
            redir_pend_q  <= 1'b0;
            redir_addr_q  <= '0;
            in_isr_q      <= 1'b0;
            irq_ack_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            redir_pend_q  <= redir_pend_d;
            redir_addr_q  <= redir_addr_d;
            in_isr_q      <= in_isr_d;
            irq_ack_q     <= irq_ack_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign irq_ack     = irq_ack_q;
    assign in_isr      = in_isr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        CLK = 1'b0;
    logic        CLR, run, stall, branch_valid, irq, irq_ret;
    logic [14:0] branch_addr;
    logic        imem_req, imem_ack;
    logic [14:0] imem_addr;
    logic [15:0] imem_data;
    logic        instr_valid, irq_ack, in_isr;
    logic [15:0] instr;
    logic [14:0] instr_pc;

    int errors = 0;
    int checks = 0;
    int mem_waits = 0;
    int wait_cnt = 0;

    always #5 CLK = ~CLK;

    fetch_sequencer dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .run          (run),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_addr  (branch_addr),
        .irq          (irq),
        .irq_ret      (irq_ret),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .irq_ack      (irq_ack),
        .in_isr       (in_isr)
    );

    function automatic logic [15:0] mem_word(input logic [14:0] a);
        return {1'b0, a} ^ 16'hC3A5;
    endfunction

    // Memory model with a configurable number of wait states.
    assign imem_ack  = imem_req && (wait_cnt >= mem_waits);
    assign imem_data = mem_word(imem_addr);
    always @(posedge CLK) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    typedef struct {
        logic [14:0] pc;
        logic [15:0] word;
    } sb_t;
    sb_t exp_q[$];

    typedef struct {
        bit          run, stall, bv;
        logic [14:0] baddr;
        bit          irq, iret;
        bit          e_req;
        logic [14:0] e_addr;
        bit          e_valid;
        logic [14:0] e_pc;
        bit          e_ack, e_isr;
    } vec_t;
    vec_t vecs[21];

    function automatic vec_t v(bit r, bit s, bit b, logic [14:0] ba, bit i, bit ir,
                               bit er, logic [14:0] ea, bit ev, logic [14:0] ep,
                               bit ek, bit ei);
        vec_t x;
        x.run = r; x.stall = s; x.bv = b; x.baddr = ba; x.irq = i; x.iret = ir;
        x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_pc = ep;
        x.e_ack = ek; x.e_isr = ei;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [14:0] pc);
        sb_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Advance one clock; sample 1 ns later and score any delivered word.
    task automatic tick();
        sb_t e;
        @(posedge CLK);
        #1;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %0h word %0h expected no delivery",
                         instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(instr_pc), 32'(e.pc));
                check("sb_word", 32'(instr), 32'(e.word));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        CLR = 1'b1; run = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        branch_addr = '0; irq = 1'b0; irq_ret = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_irq_ack", 32'(irq_ack), 32'd0);
        check("rst_in_isr", 32'(in_isr), 32'd0);
        CLR = 1'b0;

        //            run st bv baddr     irq ret  req addr      vld pc        ack isr
        vecs[0]  = v(T, F, F, 15'h0000, F, F,   T, 15'h0000, F, 15'h0000, F, F);
        vecs[1]  = v(T, F, F, 15'h0000, F, F,   T, 15'h0001, T, 15'h0000, F, F);
        vecs[2]  = v(T, F, F, 15'h0000, F, F,   T, 15'h0002, T, 15'h0001, F, F);
        vecs[3]  = v(T, F, F, 15'h0000, F, F,   T, 15'h0003, T, 15'h0002, F, F);
        vecs[4]  = v(T, F, T, 15'h7FFE, F, F,   T, 15'h7FFE, F, 15'h0000, F, F);
        vecs[5]  = v(T, F, F, 15'h0000, F, F,   T, 15'h7FFF, T, 15'h7FFE, F, F);
        vecs[6]  = v(T, F, F, 15'h0000, F, F,   T, 15'h0000, T, 15'h7FFF, F, F);
        vecs[7]  = v(T, T, F, 15'h0000, F, F,   F, 15'h0001, T, 15'h0000, F, F);
        vecs[8]  = v(T, T, T, 15'h0040, F, F,   F, 15'h0040, F, 15'h0000, F, F);
        vecs[9]  = v(T, F, F, 15'h0000, F, F,   T, 15'h0040, F, 15'h0000, F, F);
        vecs[10] = v(F, F, F, 15'h0000, F, F,   F, 15'h0041, T, 15'h0040, F, F);
        vecs[11] = v(F, F, F, 15'h0000, F, F,   F, 15'h0041, F, 15'h0000, F, F);
        vecs[12] = v(F, F, T, 15'h0020, F, F,   F, 15'h0020, F, 15'h0000, F, F);
        vecs[13] = v(T, F, F, 15'h0000, F, F,   T, 15'h0020, F, 15'h0000, F, F);
        vecs[14] = v(T, F, F, 15'h0000, T, F,   T, 15'h0010, T, 15'h0020, T, T);
        vecs[15] = v(T, F, F, 15'h0000, T, F,   T, 15'h0011, T, 15'h0010, F, T);
        vecs[16] = v(T, F, F, 15'h0000, F, T,   T, 15'h0021, T, 15'h0011, F, F);
        vecs[17] = v(T, F, F, 15'h0000, F, T,   T, 15'h0022, T, 15'h0021, F, F);
        vecs[18] = v(T, F, T, 15'h0030, T, F,   T, 15'h0030, F, 15'h0000, F, F);
        vecs[19] = v(T, F, F, 15'h0000, T, F,   T, 15'h0010, T, 15'h0030, T, T);
        vecs[20] = v(F, F, F, 15'h0000, F, F,   F, 15'h0011, T, 15'h0010, F, T);

        mem_waits = 0;
        for (int i = 0; i < 21; i++) begin
            run = vecs[i].run; stall = vecs[i].stall;
            branch_valid = vecs[i].bv; branch_addr = vecs[i].baddr;
            irq = vecs[i].irq; irq_ret = vecs[i].iret;
            if (vecs[i].e_valid) push_exp(vecs[i].e_pc);
            tick();
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_irq_ack", i), 32'(irq_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_in_isr", i), 32'(in_isr), 32'(vecs[i].e_isr));
        end
        run = 1'b0; stall = 1'b0; branch_valid = 1'b0; irq = 1'b0; irq_ret = 1'b0;

        // Branch during a two-wait-state request.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        mem_waits = 2;
        run = 1'b1;
        tick();
        check("ws_req", 32'(imem_req), 32'd1);
        check("ws_addr0", 32'(imem_addr), 32'd0);
        branch_valid = 1'b1; branch_addr = 15'h0100;
        tick();
        branch_valid = 1'b0; branch_addr = 15'h0000;
        check("ws_stable1", 32'(imem_addr), 32'd0);
        tick();
        check("ws_stable2", 32'(imem_addr), 32'd0);
        check("ws_stable_req", 32'(imem_req), 32'd1);
        tick();
        check("ws_redir_addr", 32'(imem_addr), 32'h0100);
        check("ws_discard", 32'(instr_valid), 32'd0);
        push_exp(15'h0100);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = instr_valid;
        end
        check("ws_deliver_seen", 32'(seen), 32'd1);

        // Interrupt entry under wait states, then reset mid-wait.
        irq = 1'b1;
        push_exp(15'h0101);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = irq_ack;
        end
        irq = 1'b0;
        check("wi_irq_ack_seen", 32'(seen), 32'd1);
        check("wi_addr", 32'(imem_addr), 32'h0010);
        check("wi_in_isr", 32'(in_isr), 32'd1);
        tick();
        check("wi_midwait_req", 32'(imem_req), 32'd1);
        check("wi_midwait_addr", 32'(imem_addr), 32'h0010);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        run = 1'b0;
        check("clr_req", 32'(imem_req), 32'd0);
        check("clr_addr", 32'(imem_addr), 32'd0);
        check("clr_in_isr", 32'(in_isr), 32'd0);
        check("clr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("clr_stays_idle", 32'(imem_req), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
